// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the accumulator CPU and its program loader.
//   loader_state_e : program-loader FSM states
//   LOADER_HEADER  : frame start byte
//   PROG_DEPTH     : program memory depth in words
//   PROG_AW        : program memory address width
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_e;

    localparam logic [7:0] LOADER_HEADER = 8'hA5;
    localparam int         PROG_DEPTH    = 16;
    localparam int         PROG_AW       = 4;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: writes a framed byte stream into the 16x8 program memory and
// holds the CPU in reset until a complete, valid frame has been loaded.
//
// Frame: LOADER_HEADER, count N (1..PROG_DEPTH), N data bytes,
//        [checksum = sum of data mod 256, only when LOADER_CKSUM_EN is defined]
//
// Build option: LOADER_CKSUM_EN -- adds the trailing checksum byte and check.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-low reset
//   i_rx_data/valid    incoming byte stream
//   o_rx_ready         byte accepted when i_rx_valid && o_rx_ready
//   o_mem_we/addr/wdata program memory write port (one-cycle pulse)
//   o_cpu_rst_n        CPU reset, low until a good load completes
//   o_busy/done/err    frame in progress / last load good / last load rejected
//
// state | meaning
// IDLE  | after reset, waiting for header, other bytes dropped
// COUNT | header seen, next byte is the word count
// DATA  | writing data bytes to memory
// CKSUM | waiting for the checksum byte (LOADER_CKSUM_EN only)
// DONE  | good load, CPU released, waiting for a new header
// ERR   | rejected load, CPU held, waiting for a new header
module prog_loader
    import cpu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic               o_mem_we,
    output logic [PROG_AW-1:0] o_mem_addr,
    output logic [7:0]         o_mem_wdata,
    output logic               o_cpu_rst_n,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    loader_state_e      state_q, state_d;
    logic               rx_ready_q;
    logic               we_q;
    logic [PROG_AW-1:0] mem_addr_q;
    logic [7:0]         wdata_q;
    logic [PROG_AW-1:0] addr_q;
    logic [4:0]         remaining_q;
`ifdef LOADER_CKSUM_EN
    logic [7:0]         sum_q;
`endif

    logic rx_accept;
    logic is_header;
    logic count_bad;

    assign rx_accept = i_rx_valid && rx_ready_q;
    assign is_header = (i_rx_data == LOADER_HEADER);
    assign count_bad = (i_rx_data == 8'd0) || (i_rx_data > 8'(PROG_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_accept) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (is_header) state_d = COUNT;
                end
                COUNT: begin
                    state_d = count_bad ? ERR : DATA;
                end
                DATA: begin
                    if (remaining_q == 5'd1) begin
`ifdef LOADER_CKSUM_EN
                        state_d = CKSUM;
`else
                        state_d = DONE;
`endif
                    end
                end
                CKSUM: begin
`ifdef LOADER_CKSUM_EN
                    state_d = (i_rx_data == sum_q) ? DONE : ERR;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        o_cpu_rst_n = 1'b0;
        case (state_q)
            COUNT, DATA, CKSUM: o_busy = 1'b1;
            DONE: begin
                o_done      = 1'b1;
                o_cpu_rst_n = 1'b1;
            end
            ERR:     o_err = 1'b1;
            default: ;
        endcase
    end

    // Write port is registered: the address/data of the accepted byte are
    // presented together with the pulse in the following cycle, while addr_q
    // has already moved on to the next word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
`ifdef LOADER_CKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            rx_ready_q <= 1'b1;
            we_q       <= rx_accept && (state_q == DATA);
            if (rx_accept && (state_q == COUNT)) begin
                remaining_q <= i_rx_data[4:0];
                addr_q      <= '0;
`ifdef LOADER_CKSUM_EN
                sum_q       <= '0;
`endif
            end
            if (rx_accept && (state_q == DATA)) begin
                mem_addr_q  <= addr_q;
                wdata_q     <= i_rx_data;
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 5'd1;
`ifdef LOADER_CKSUM_EN
                sum_q       <= sum_q + i_rx_data;
`endif
            end
        end
    end

    assign o_rx_ready  = rx_ready_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_rx_ready;
    logic       o_mem_we;
    logic [3:0] o_mem_addr;
    logic [7:0] o_mem_wdata;
    logic       o_cpu_rst_n;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int vectors = 0;
    int miscompares = 0;

`ifdef LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic [11:0] wr_q[$];

    prog_loader dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    // One record per cycle with we high, so a stretched pulse shows up as an
    // extra write.
    always @(negedge i_clk) begin
        if (i_rst && o_mem_we) wr_q.push_back({o_mem_addr, o_mem_wdata});
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom);
            @(negedge i_clk);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        vectors++;
        if (o_rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_ready: got %b want 1", o_rx_ready);
        end
        @(negedge i_clk);
    endtask

    task automatic check_flags(input string name, input logic done, input logic err,
                               input logic busy, input logic cpu_rst_n);
        vectors++;
        if ({o_done, o_err, o_busy, o_cpu_rst_n} !== {done, err, busy, cpu_rst_n}) begin
            miscompares++;
            $display("FAIL %s flags done/err/busy/cpu_rst_n: got %b%b%b%b want %b%b%b%b",
                     name, o_done, o_err, o_busy, o_cpu_rst_n, done, err, busy, cpu_rst_n);
        end
    endtask

    // Reference: the frame's outcome and write list follow directly from the
    // frame rules (count range, checksum = data sum mod 256).
    task automatic run_frame(input string name, input logic [7:0] cnt,
                             input logic [7:0] data[$], input logic [7:0] ck_delta,
                             input int max_gap);
        bit          bad_count;
        bit          exp_ok;
        int          sum;
        logic [11:0] exp_wr[$];
        bad_count = (cnt == 0) || (cnt > 16);
        sum = 0;
        wr_q.delete();
        send_byte(8'hA5, $urandom_range(max_gap, 0));
        send_byte(cnt, $urandom_range(max_gap, 0));
        if (!bad_count) begin
            for (int i = 0; i < int'(cnt); i++) begin
                send_byte(data[i], $urandom_range(max_gap, 0));
                sum = (sum + int'(data[i])) % 256;
                exp_wr.push_back({i[3:0], data[i]});
            end
            if (CK_EN) send_byte(8'(sum) + ck_delta, $urandom_range(max_gap, 0));
        end
        i_rx_valid = 1'b0;
        exp_ok = !bad_count && (!CK_EN || ck_delta == 8'd0);
        check_flags(name, exp_ok, !exp_ok, 1'b0, exp_ok);
        @(negedge i_clk);
        vectors++;
        if (wr_q.size() != exp_wr.size()) begin
            miscompares++;
            $display("FAIL %s write count: got %0d want %0d", name, wr_q.size(), exp_wr.size());
        end else begin
            for (int i = 0; i < exp_wr.size(); i++) begin
                vectors++;
                if (wr_q[i] !== exp_wr[i]) begin
                    miscompares++;
                    $display("FAIL %s write %0d addr/data: got %h/%h want %h/%h", name, i,
                             wr_q[i][11:8], wr_q[i][7:0], exp_wr[i][11:8], exp_wr[i][7:0]);
                end
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors++;
        if ({o_rx_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_rst_n, o_busy, o_done, o_err}
            !== 18'd0) begin
            miscompares++;
            $display("FAIL %s: got ready=%b we=%b addr=%h wdata=%h cpu_rst_n=%b busy=%b done=%b err=%b want all 0",
                     name, o_rx_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_rst_n,
                     o_busy, o_done, o_err);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_values("reset");
        i_rst = 1'b1;
        @(negedge i_clk);
        vectors++;
        if (o_rx_ready !== 1'b1 || o_cpu_rst_n !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got ready=%b cpu_rst_n=%b want 1/0", o_rx_ready, o_cpu_rst_n);
        end
    endtask

    task automatic test_good_load();
        logic [7:0] d[$] = '{8'h1E, 8'hE0, 8'hF0};
        run_frame("good_load", 8'h03, d, 8'h00, 0);
    endtask

    task automatic test_bad_cksum();
        logic [7:0] d[$]  = '{8'h11, 8'h22};
        logic [7:0] d2[$] = '{8'h5A, 8'h01};
        // 11+22=33, so 00 is off by CD
        run_frame("bad_cksum", 8'h02, d, 8'hCD, 0);
        run_frame("bad_cksum_recover", 8'h02, d2, 8'h00, 1);
    endtask

    task automatic test_bad_count();
        logic [7:0] d[$];
        run_frame("count_zero", 8'h00, d, 8'h00, 0);
        run_frame("count_17", 8'h11, d, 8'h00, 0);
    endtask

    task automatic test_full_depth();
        logic [7:0] d[$];
        for (int i = 0; i < 16; i++) d.push_back(8'(i));
        run_frame("full_depth", 8'h10, d, 8'h00, 3);
    endtask

    task automatic test_reload_noise();
        send_byte(8'h3C, 0);
        i_rx_valid = 1'b0;
        check_flags("noise_in_done", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5, 0);
        i_rx_valid = 1'b0;
        check_flags("reload_header", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge i_clk);
        check_flags("hold_no_valid", 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h01, 0);
        send_byte(8'h77, 0);
        if (CK_EN) send_byte(8'h77, 0);
        i_rx_valid = 1'b0;
        check_flags("reload_done", 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d[$] = '{8'hC3, 8'h3C, 8'h99};
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        i_rx_valid = 1'b0;
        #1 i_rst = 1'b0;
        #1 check_reset_values("reset_midframe");
        @(negedge i_clk);
        check_reset_values("reset_midframe_held");
        i_rst = 1'b1;
        @(negedge i_clk);
        run_frame("after_reset", 8'h03, d, 8'h00, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            logic [7:0] d[$];
            logic [7:0] cnt;
            logic [7:0] delta;
            cnt = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(40, 17)) * 8'(f % 2)
                                              : 8'($urandom_range(16, 1));
            delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            for (int i = 0; i < int'(cnt); i++) d.push_back(8'($urandom));
            run_frame("random", cnt, d, delta, $urandom_range(2, 0));
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_cksum();
        test_bad_count();
        test_full_depth();
        test_reload_noise();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
